// File: rtl/mux_pkg.sv
// Shared constants for the 2:1 stream mux and the 1:2 demux that splits the stream back out.
// Both ends of the link use the same SEL_* tag values.
package mux_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCK_A = 2'd1;
  localparam logic [1:0] ST_LOCK_B = 2'd2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    LOCK_A = ST_LOCK_A,
    LOCK_B = ST_LOCK_B
  } arb_state_t;

endpackage

// File: rtl/mux2to1_stream_if.sv
// Bundle of the two input streams and the tagged output stream of mux2to1_stream.
// The slave modport is the mux itself; master is whoever drives the sources and sinks the output.
interface mux2to1_stream_if #(
  parameter int WIDTH = 8
);

  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             a_ready;

  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
  logic             b_ready;

  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_last;
  logic             y_sel;
  logic             y_ready;

  modport slave (
    input  a_valid, a_data, a_last,
    output a_ready,
    input  b_valid, b_data, b_last,
    output b_ready,
    output y_valid, y_data, y_last, y_sel,
    input  y_ready
  );

  modport master (
    output a_valid, a_data, a_last,
    input  a_ready,
    output b_valid, b_data, b_last,
    input  b_ready,
    input  y_valid, y_data, y_last, y_sel,
    output y_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin packet arbiter: once a source wins it keeps the grant until its last beat,
// then priority passes to the other source.
module rr_arb2
  import mux_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic a_last,
  input  logic a_fire,
  input  logic b_valid,
  input  logic b_last,
  input  logic b_fire,
  output logic grant_a,
  output logic grant_b
);

  arb_state_t state, state_nxt;
  logic       prio, prio_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= SEL_A;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  // Grant is kept apart from next-state so the fire feedback from the top never forms a comb loop.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (state)
      IDLE: begin
        if (a_valid && (!b_valid || prio == SEL_A)) grant_a = 1'b1;
        else if (b_valid)                           grant_b = 1'b1;
      end
      LOCK_A:  grant_a = a_valid;
      LOCK_B:  grant_b = b_valid;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    unique case (state)
      IDLE: begin
        if (a_fire) begin
          if (a_last) prio_nxt  = SEL_B;
          else        state_nxt = LOCK_A;
        end else if (b_fire) begin
          if (b_last) prio_nxt  = SEL_A;
          else        state_nxt = LOCK_B;
        end
      end
      LOCK_A: begin
        if (a_fire && a_last) begin
          state_nxt = IDLE;
          prio_nxt  = SEL_B;
        end
      end
      LOCK_B: begin
        if (b_fire && b_last) begin
          state_nxt = IDLE;
          prio_nxt  = SEL_A;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/mux2to1_stream.sv
// Round-robin, packet-atomic 2:1 stream mux with a registered output tagged by source (y_sel).
// The output register accepts a new beat whenever it is empty or being drained this cycle.
module mux2to1_stream
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  mux2to1_stream_if.slave bus
);

  logic load;
  logic grant_a, grant_b;
  logic a_fire, b_fire;

  assign load = !bus.y_valid || bus.y_ready;

  // rst_n gates the readies so nothing is accepted while reset is held.
  assign bus.a_ready = rst_n && grant_a && load;
  assign bus.b_ready = rst_n && grant_b && load;

  assign a_fire = bus.a_valid && bus.a_ready;
  assign b_fire = bus.b_valid && bus.b_ready;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (bus.a_valid),
    .a_last  (bus.a_last),
    .a_fire  (a_fire),
    .b_valid (bus.b_valid),
    .b_last  (bus.b_last),
    .b_fire  (b_fire),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y_valid <= 1'b0;
      bus.y_data  <= {WIDTH{1'b0}};
      bus.y_last  <= 1'b0;
      bus.y_sel   <= SEL_A;
    end else if (load) begin
      if (a_fire) begin
        bus.y_valid <= 1'b1;
        bus.y_data  <= bus.a_data;
        bus.y_last  <= bus.a_last;
        bus.y_sel   <= SEL_A;
      end else if (b_fire) begin
        bus.y_valid <= 1'b1;
        bus.y_data  <= bus.b_data;
        bus.y_last  <= bus.b_last;
        bus.y_sel   <= SEL_B;
      end else begin
        bus.y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2to1_stream.sv
// Bench for mux2to1_stream: directed scenarios plus randomized traffic, checked every cycle
// against a packet-level arbitration model and per-source scoreboards.
module tb_mux2to1_stream;
  import mux_pkg::*;

  typedef struct packed { logic [7:0] data; logic last; logic gap; } tx_t;
  typedef struct packed { logic [7:0] data; logic last; logic sel; } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux2to1_stream_if #(.WIDTH(8)) bus ();

  mux2to1_stream #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    checkCount = 0;
  int    passCount  = 0;
  int    cycle      = 0;
  tx_t   txA[$], txB[$];
  bit    aBusy = 0, bBusy = 0, aFired = 0, bFired = 0;
  bit    randReady = 0;
  beat_t outLog[$];
  int    outCycle[$];
  beat_t expSeq[$];

  // Model state: the source owning an open packet (0 none, 1 A, 2 B), whose turn it is,
  // the beat that must be sitting in the output register, and the beats in flight per source.
  int    owner = 0;
  logic  prio = SEL_A;
  logic  mValid = 1'b0;
  beat_t mBeat = '0;
  beat_t qA[$], qB[$];

  function automatic tx_t mkTx(logic [7:0] d, logic l, logic g);
    tx_t t;
    t.data = d; t.last = l; t.gap = g;
    return t;
  endfunction

  function automatic beat_t mkBeat(logic [7:0] d, logic l, logic s);
    beat_t b;
    b.data = d; b.last = l; b.sel = s;
    return b;
  endfunction

  task automatic checkBit(string name, logic act, logic exp);
    checkCount++;
    if (act !== exp) $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cycle);
    else passCount++;
  endtask

  task automatic checkByte(string name, logic [7:0] act, logic [7:0] exp);
    checkCount++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    else passCount++;
  endtask

  task automatic checkInt(string name, int act, int exp);
    checkCount++;
    if (act != exp) $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    else passCount++;
  endtask

  task automatic checkOutput();
    logic  load, ga, gb;
    beat_t got, exp;
    checkBit("y_valid", bus.y_valid, mValid);
    if (mValid) begin
      checkByte("y_data", bus.y_data, mBeat.data);
      checkBit("y_last", bus.y_last, mBeat.last);
      checkBit("y_sel", bus.y_sel, mBeat.sel);
    end
    if (bus.y_valid && bus.y_ready) begin
      got = mkBeat(bus.y_data, bus.y_last, bus.y_sel);
      if (got.sel == SEL_A) begin
        checkBit("sb_a_present", qA.size() > 0, 1'b1);
        if (qA.size() > 0) begin
          exp = qA.pop_front();
          checkByte("sb_a_data", got.data, exp.data);
          checkBit("sb_a_last", got.last, exp.last);
        end
      end else begin
        checkBit("sb_b_present", qB.size() > 0, 1'b1);
        if (qB.size() > 0) begin
          exp = qB.pop_front();
          checkByte("sb_b_data", got.data, exp.data);
          checkBit("sb_b_last", got.last, exp.last);
        end
      end
      outLog.push_back(got);
      outCycle.push_back(cycle);
    end

    load = !mValid || bus.y_ready;
    ga = 1'b0;
    gb = 1'b0;
    if (owner == 1)                          ga = bus.a_valid;
    else if (owner == 2)                     gb = bus.b_valid;
    else if (bus.a_valid && bus.b_valid) begin
      if (prio == SEL_A) ga = 1'b1;
      else               gb = 1'b1;
    end else begin
      ga = bus.a_valid;
      gb = bus.b_valid;
    end
    checkBit("a_ready", bus.a_ready, ga && load);
    checkBit("b_ready", bus.b_ready, gb && load);
    checkBit("ready_exclusive", bus.a_ready && bus.b_ready, 1'b0);

    aFired = bus.a_valid && bus.a_ready;
    bFired = bus.b_valid && bus.b_ready;
    if (aFired) begin
      qA.push_back(mkBeat(bus.a_data, bus.a_last, SEL_A));
      owner = bus.a_last ? 0 : 1;
      if (bus.a_last) prio = SEL_B;
    end
    if (bFired) begin
      qB.push_back(mkBeat(bus.b_data, bus.b_last, SEL_B));
      owner = bus.b_last ? 0 : 2;
      if (bus.b_last) prio = SEL_A;
    end
    if (load) begin
      if (aFired)      begin mValid = 1'b1; mBeat = mkBeat(bus.a_data, bus.a_last, SEL_A); end
      else if (bFired) begin mValid = 1'b1; mBeat = mkBeat(bus.b_data, bus.b_last, SEL_B); end
      else             mValid = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (!rst_n) begin
        checkBit("rst_y_valid", bus.y_valid, 1'b0);
        checkByte("rst_y_data", bus.y_data, 8'h00);
        checkBit("rst_y_last", bus.y_last, 1'b0);
        checkBit("rst_y_sel", bus.y_sel, 1'b0);
        checkBit("rst_a_ready", bus.a_ready, 1'b0);
        checkBit("rst_b_ready", bus.b_ready, 1'b0);
        owner  = 0;
        prio   = SEL_A;
        mValid = 1'b0;
        qA.delete();
        qB.delete();
        aFired = 0;
        bFired = 0;
      end else begin
        checkOutput();
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock step: advance each source past beats accepted at this edge, present the next one.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    if (aBusy && aFired) begin txA.delete(0); aBusy = 0; end
    if (bBusy && bFired) begin txB.delete(0); bBusy = 0; end
    if (!aBusy) begin
      if (txA.size() > 0 && txA[0].gap) begin
        txA.delete(0);
        bus.a_valid = 1'b0;
      end else if (txA.size() > 0) begin
        bus.a_valid = 1'b1; bus.a_data = txA[0].data; bus.a_last = txA[0].last; aBusy = 1;
      end else bus.a_valid = 1'b0;
    end
    if (!bBusy) begin
      if (txB.size() > 0 && txB[0].gap) begin
        txB.delete(0);
        bus.b_valid = 1'b0;
      end else if (txB.size() > 0) begin
        bus.b_valid = 1'b1; bus.b_data = txB[0].data; bus.b_last = txB[0].last; bBusy = 1;
      end else bus.b_valid = 1'b0;
    end
    if (randReady) bus.y_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic flushSources();
    txA.delete();
    txB.delete();
    aBusy = 0;
    bBusy = 0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    flushSources();
    repeat (3) applyStimulus();
    rst_n = 1'b1;
  endtask

  task automatic waitOutputs(string name, int target, int budget);
    int n = 0;
    while (outLog.size() < target && n < budget) begin
      applyStimulus();
      n++;
    end
    checkBit(name, outLog.size() >= target, 1'b1);
  endtask

  task automatic checkSeq(string tag, int base);
    if (outLog.size() >= base + expSeq.size()) begin
      foreach (expSeq[i]) begin
        checkByte({tag, "_data"}, outLog[base+i].data, expSeq[i].data);
        checkBit({tag, "_last"}, outLog[base+i].last, expSeq[i].last);
        checkBit({tag, "_sel"}, outLog[base+i].sel, expSeq[i].sel);
      end
    end
  endtask

  initial begin
    int base, selA;
    logic [7:0] d;
    logic l;

    bus.a_valid = 1'b0; bus.a_data = '0; bus.a_last = 1'b0;
    bus.b_valid = 1'b0; bus.b_data = '0; bus.b_last = 1'b0;
    bus.y_ready = 1'b1;

    $display("[TB] reset and first beat");
    txA.push_back(mkTx(8'h11, 1'b1, 1'b0));
    repeat (3) applyStimulus();
    checkBit("t1_rst_y_valid", bus.y_valid, 1'b0);
    checkBit("t1_rst_y_sel", bus.y_sel, 1'b0);
    checkBit("t1_rst_a_ready", bus.a_ready, 1'b0);
    checkBit("t1_rst_b_ready", bus.b_ready, 1'b0);
    rst_n = 1'b1;
    applyStimulus();
    checkBit("t1_y_valid", bus.y_valid, 1'b1);
    checkByte("t1_y_data", bus.y_data, 8'h11);
    checkBit("t1_y_sel", bus.y_sel, 1'b0);
    checkBit("t1_y_last", bus.y_last, 1'b1);

    $display("[TB] simultaneous single-beat requests");
    applyReset();
    base = outLog.size();
    txA.push_back(mkTx(8'hA0, 1'b1, 1'b0)); txA.push_back(mkTx(8'hA1, 1'b1, 1'b0));
    txB.push_back(mkTx(8'hB0, 1'b1, 1'b0)); txB.push_back(mkTx(8'hB1, 1'b1, 1'b0));
    waitOutputs("t2_done", base + 4, 20);
    expSeq = '{mkBeat(8'hA0, 1, 0), mkBeat(8'hB0, 1, 1), mkBeat(8'hA1, 1, 0), mkBeat(8'hB1, 1, 1)};
    checkSeq("t2", base);
    if (outLog.size() >= base + 4)
      for (int i = 1; i < 4; i++) checkInt("t2_no_bubble", outCycle[base+i] - outCycle[base+i-1], 1);

    $display("[TB] packet lock");
    applyReset();
    base = outLog.size();
    txA.push_back(mkTx(8'h01, 1'b0, 1'b0)); txA.push_back(mkTx(8'h02, 1'b0, 1'b0));
    txA.push_back(mkTx(8'h00, 1'b0, 1'b1)); txA.push_back(mkTx(8'h03, 1'b1, 1'b0));
    txB.push_back(mkTx(8'hB5, 1'b1, 1'b0));
    waitOutputs("t3_done", base + 4, 20);
    expSeq = '{mkBeat(8'h01, 0, 0), mkBeat(8'h02, 0, 0), mkBeat(8'h03, 1, 0), mkBeat(8'hB5, 1, 1)};
    checkSeq("t3", base);
    if (outLog.size() >= base + 4) checkInt("t3_b_after_a", outCycle[base+3] - outCycle[base+2], 1);

    $display("[TB] backpressure");
    applyReset();
    base = outLog.size();
    bus.y_ready = 1'b0;
    for (int i = 0; i < 4; i++) txA.push_back(mkTx(8'h21 + 8'(i), 1'(i == 3), 1'b0));
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkBit("t4_hold_valid", bus.y_valid, 1'b1);
      checkByte("t4_hold_data", bus.y_data, 8'h21);
      checkBit("t4_a_ready", bus.a_ready, 1'b0);
    end
    bus.y_ready = 1'b1;
    waitOutputs("t4_done", base + 4, 20);
    expSeq = '{mkBeat(8'h21, 0, 0), mkBeat(8'h22, 0, 0), mkBeat(8'h23, 0, 0), mkBeat(8'h24, 1, 0)};
    checkSeq("t4", base);

    $display("[TB] reset mid-packet");
    applyReset();
    base = outLog.size();
    for (int i = 0; i < 4; i++) txB.push_back(mkTx(8'h31 + 8'(i), 1'(i == 3), 1'b0));
    waitOutputs("t5_first", base + 1, 20);
    checkByte("t5_beat2", bus.y_data, 8'h32);
    rst_n = 1'b0;
    #1;
    checkBit("t5_async_y_valid", bus.y_valid, 1'b0);
    checkBit("t5_async_b_ready", bus.b_ready, 1'b0);
    flushSources();
    repeat (2) applyStimulus();
    rst_n = 1'b1;
    base = outLog.size();
    txA.push_back(mkTx(8'h41, 1'b1, 1'b0));
    txB.push_back(mkTx(8'h51, 1'b1, 1'b0));
    waitOutputs("t5_done", base + 2, 20);
    expSeq = '{mkBeat(8'h41, 1, 0), mkBeat(8'h51, 1, 1)};
    checkSeq("t5", base);

    $display("[TB] throughput");
    applyReset();
    base = outLog.size();
    for (int i = 0; i < 50; i++) begin
      d = 8'($urandom); l = (i == 49) || ($urandom_range(0, 3) == 0);
      txA.push_back(mkTx(d, l, 1'b0));
      d = 8'($urandom); l = (i == 49) || ($urandom_range(0, 3) == 0);
      txB.push_back(mkTx(d, l, 1'b0));
    end
    waitOutputs("t6_done", base + 100, 400);
    if (outLog.size() >= base + 100) begin
      checkInt("t6_cycles", outCycle[base+99] - outCycle[base] + 2, 101);
      selA = 0;
      for (int i = 0; i < 100; i++) if (outLog[base+i].sel == SEL_A) selA++;
      checkInt("t6_a_count", selA, 50);
    end

    $display("[TB] random traffic with random backpressure");
    applyReset();
    base = outLog.size();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) == 0) txA.push_back(mkTx(8'h00, 1'b0, 1'b1));
      txA.push_back(mkTx(8'($urandom), (i == 29) || ($urandom_range(0, 2) == 0), 1'b0));
      if ($urandom_range(0, 9) == 0) txB.push_back(mkTx(8'h00, 1'b0, 1'b1));
      txB.push_back(mkTx(8'($urandom), (i == 29) || ($urandom_range(0, 2) == 0), 1'b0));
    end
    randReady = 1;
    waitOutputs("t7_done", base + 60, 3000);
    randReady = 0;
    bus.y_ready = 1'b1;
    repeat (3) applyStimulus();
    checkInt("t7_a_drained", qA.size(), 0);
    checkInt("t7_b_drained", qB.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
